// File: rtl/tone_pkg.sv
// Shared definitions for the chromatic square-wave tone generator:
// note encodings, octave-0 frequency table, FSM states and half-period helper.
package tone_pkg;

    localparam int         NUM_NOTES = 12;
    localparam logic [3:0] NOTE_REST = 4'd15;

    // Octave-0 note frequencies in millihertz, C0 through B0.
    localparam longint FREQ0_MHZ [NUM_NOTES] = '{
        16352, 17324, 18354, 19445, 20602, 21827,
        23125, 24500, 25957, 27500, 29135, 30868
    };

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        RELEASE = 2'd2
    } state_t;

    function automatic longint half0_calc(input longint clk_hz, input logic [3:0] note);
        return (clk_hz * 1000) / (2 * FREQ0_MHZ[note]);
    endfunction

endpackage

// File: rtl/tone_if.sv
// Keyboard-side control and speaker-side status bundle of the tone generator.
// The cycles field exists only when TONE_CYCLE_CNT_EN is defined.
interface tone_if;

    logic       key_on;
    logic [3:0] note_sel;
    logic [2:0] octave;
    logic       tone;
    logic       active;
    logic       half_tick;
`ifdef TONE_CYCLE_CNT_EN
    logic [7:0] cycles;
`endif

    modport master (
        output key_on, note_sel, octave,
        input  tone, active, half_tick
`ifdef TONE_CYCLE_CNT_EN
        , input cycles
`endif
    );

    modport slave (
        input  key_on, note_sel, octave,
        output tone, active, half_tick
`ifdef TONE_CYCLE_CNT_EN
        , output cycles
`endif
    );

endinterface

// File: rtl/tone_cycle_cnt.sv
// Saturating count of full tone periods since the note started.
// Present only when TONE_CYCLE_CNT_EN is defined.
`ifdef TONE_CYCLE_CNT_EN
module tone_cycle_cnt (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       rise,
    output logic [7:0] cycles
);

    logic [7:0] cnt_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_reg <= 8'd0;
        end else if (clear) begin
            cnt_reg <= 8'd0;
        end else if (rise && (cnt_reg != 8'hFF)) begin
            cnt_reg <= cnt_reg + 8'd1;
        end
    end

    assign cycles = cnt_reg;

endmodule
`endif

// File: rtl/tone_gen.sv
// Run-time selectable square-wave note generator with key gating, boundary-aligned
// note changes and click-free release. Optional period counter: TONE_CYCLE_CNT_EN.
module tone_gen
    import tone_pkg::*;
#(
    parameter int CLK_HZ  = 50_000_000,
    parameter int CNT_W   = 22,
    parameter int OCT_MAX = 7
) (
    input logic   clk,
    input logic   reset,
    tone_if.slave bus
);

    typedef logic [CNT_W-1:0] cnt_t;
    localparam cnt_t CNT_ONE = cnt_t'(1);

    // Half-period table indexed directly by the latched note; rest codes map to 0.
    cnt_t half0_tab [16];
    genvar gi;
    for (gi = 0; gi < 16; gi++) begin : g_half0
        if (gi < NUM_NOTES) begin : g_note
            assign half0_tab[gi] = cnt_t'(half0_calc(longint'(CLK_HZ), 4'(gi)));
        end else begin : g_rest
            assign half0_tab[gi] = '0;
        end
    end

    state_t     state_reg, state_next;
    cnt_t       cnt_reg, cnt_next;
    logic       tone_reg, tone_next;
    logic       tick_reg, tick_next;
    logic [3:0] note_reg, note_next;
    logic [2:0] oct_reg, oct_next;
    logic [2:0] oct_clamped;
    cnt_t       h_val;
    logic       rest, toggle, latch;

    assign oct_clamped = (bus.octave > 3'(OCT_MAX)) ? 3'(OCT_MAX) : bus.octave;
    assign h_val       = half0_tab[note_reg] >> oct_reg;
    assign rest        = (note_reg >= 4'(NUM_NOTES));
    assign toggle      = (state_reg != IDLE) && !rest && (cnt_reg == h_val - CNT_ONE);

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        tone_next  = tone_reg;
        latch      = 1'b0;
        case (state_reg)
            IDLE: begin
                cnt_next  = '0;
                tone_next = 1'b0;
                if (bus.key_on) begin
                    latch      = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (rest) begin
                    // No half-period boundary exists while resting, so track inputs freely.
                    cnt_next  = '0;
                    tone_next = 1'b0;
                    latch     = 1'b1;
                    if (!bus.key_on) begin
                        state_next = IDLE;
                    end
                end else begin
                    if (toggle) begin
                        cnt_next  = '0;
                        tone_next = ~tone_reg;
                        latch     = 1'b1;
                    end else begin
                        cnt_next = cnt_reg + CNT_ONE;
                    end
                    if (!bus.key_on) begin
                        if (!tone_reg || toggle) begin
                            state_next = IDLE;
                            cnt_next   = '0;
                            tone_next  = 1'b0;
                        end else begin
                            state_next = RELEASE;
                        end
                    end
                end
            end
            RELEASE: begin
                // tone is high here, so the next toggle always lands it low.
                if (toggle || rest) begin
                    cnt_next   = '0;
                    tone_next  = 1'b0;
                    latch      = 1'b1;
                    state_next = bus.key_on ? RUN : IDLE;
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                    if (bus.key_on) begin
                        state_next = RUN;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
                tone_next  = 1'b0;
            end
        endcase
        tick_next = (tone_next != tone_reg);
        note_next = latch ? bus.note_sel : note_reg;
        oct_next  = latch ? oct_clamped : oct_reg;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            tone_reg  <= 1'b0;
            tick_reg  <= 1'b0;
            note_reg  <= NOTE_REST;
            oct_reg   <= 3'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            tone_reg  <= tone_next;
            tick_reg  <= tick_next;
            note_reg  <= note_next;
            oct_reg   <= oct_next;
        end
    end

    assign bus.tone      = tone_reg;
    assign bus.active    = (state_reg != IDLE);
    assign bus.half_tick = tick_reg;

`ifdef TONE_CYCLE_CNT_EN
    tone_cycle_cnt u_cycle_cnt (
        .clk    (clk),
        .reset  (reset),
        .clear  (state_next == IDLE),
        .rise   (tone_next & ~tone_reg),
        .cycles (bus.cycles)
    );
`endif

endmodule

// File: tb/tb_tone_gen.sv
// Scoreboard bench for tone_gen: expected toggle cycles and levels are queued as
// stimulus is applied and matched against every half_tick the DUT produces.
module tb_tone_gen;

    localparam int CLK_HZ  = 400_000;
    localparam int OCT_MAX = 6;
    localparam longint FREQ_TB [12] = '{
        16352, 17324, 18354, 19445, 20602, 21827,
        23125, 24500, 25957, 27500, 29135, 30868
    };

    typedef struct {
        int   cyc;
        logic tone;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   cyc   = 0;
    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t sb [$];
    exp_t mon_e;

    tone_if bus ();

    tone_gen #(
        .CLK_HZ  (CLK_HZ),
        .CNT_W   (22),
        .OCT_MAX (OCT_MAX)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int h_exp(input int n, input int o);
        int oo;
        oo = (o > OCT_MAX) ? OCT_MAX : o;
        return int'((longint'(CLK_HZ) * 1000 / (2 * FREQ_TB[n])) >> oo);
    endfunction

    task automatic push(input int c, input logic t);
        exp_t e;
        e.cyc  = c;
        e.tone = t;
        sb.push_back(e);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic wait_empty(input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            check("sb_timeout", sb.size(), 0);
            sb.delete();
        end
    endtask

    always @(negedge clk) begin
        if (reset && bus.half_tick) begin
            $display("tick cyc=%0d tone=%0d", cyc, bus.tone);
            check("tick_expected", int'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                check("tick_cycle", cyc, mon_e.cyc);
                check("tick_tone", int'(bus.tone), int'(mon_e.tone));
            end
        end
    end

    initial begin
        int n, t, h, h2, h3;
        bus.key_on   = 1'b0;
        bus.note_sel = 4'd0;
        bus.octave   = 3'd0;

        #1;
        check("rst_tone", int'(bus.tone), 0);
        check("rst_active", int'(bus.active), 0);
        check("rst_tick", int'(bus.half_tick), 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        wait_until(cyc + 20);
        check("idle_active", int'(bus.active), 0);
        check("idle_tone", int'(bus.tone), 0);

        // A4 from IDLE: first toggle H clocks after RUN entry
        h = h_exp(9, 4);
        n = cyc;
        bus.key_on = 1'b1; bus.note_sel = 4'd9; bus.octave = 3'd4;
        t = n + 1;
        for (int k = 1; k <= 4; k++) begin
            t += h;
            push(t, logic'(k % 2 == 1));
        end
        @(negedge clk);
        check("run_active", int'(bus.active), 1);
        wait_empty(5000);

        // mid half-period change to C5 takes effect at the next boundary
        wait_until(t + 50);
        bus.note_sel = 4'd0; bus.octave = 3'd5;
        h2 = h_exp(0, 5);
        push(t + h, 1'b1);
        push(t + h + h2, 1'b0);
        push(t + h + 2 * h2, 1'b1);
        t = t + h + 2 * h2;
        wait_empty(5000);

        // release at count 100, then re-press: counter must be undisturbed
        wait_until(t + 100);
        bus.key_on = 1'b0;
        wait_until(t + 101);
        check("rel_active", int'(bus.active), 1);
        check("rel_tone", int'(bus.tone), 1);
        wait_until(t + 200);
        bus.key_on = 1'b1;
        push(t + h2, 1'b0);
        push(t + 2 * h2, 1'b1);
        t += 2 * h2;
        wait_empty(5000);

        // release runs to the falling toggle, then IDLE
        wait_until(t + 100);
        bus.key_on = 1'b0;
        push(t + h2, 1'b0);
        t += h2;
        wait_empty(5000);
        check("rel_done_active", int'(bus.active), 0);
        check("rel_done_tone", int'(bus.tone), 0);
        wait_until(t + 600);
        check("idle_quiet_active", int'(bus.active), 0);

        // octave 7 clamps to OCT_MAX; key drop with tone low goes straight to IDLE
        h3 = h_exp(9, 7);
        n = cyc;
        bus.key_on = 1'b1; bus.note_sel = 4'd9; bus.octave = 3'd7;
        t = n + 1 + h3;
        push(t, 1'b1);
        t += h3;
        push(t, 1'b0);
        wait_empty(5000);
        wait_until(t + 10);
        bus.key_on = 1'b0;
        wait_until(t + 11);
        check("drop_low_active", int'(bus.active), 0);

        // rest: no ticks, tone low, FSM stays in RUN; leaving rest needs one latch cycle
        wait_until(cyc + 5);
        n = cyc;
        bus.key_on = 1'b1; bus.note_sel = 4'd13; bus.octave = 3'd4;
        wait_until(n + 1000);
        check("rest_tone", int'(bus.tone), 0);
        check("rest_active", int'(bus.active), 1);
        check("rest_tick", int'(bus.half_tick), 0);
        n = cyc;
        bus.note_sel = 4'd9;
        t = n + 1 + h;
        push(t, 1'b1);
        wait_empty(5000);
        check("rest_exit_tone", int'(bus.tone), 1);

        // asynchronous reset mid-note with tone high
        wait_until(t + 5);
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_tone", int'(bus.tone), 0);
        check("async_rst_active", int'(bus.active), 0);
        @(negedge clk);
        bus.key_on = 1'b0;
        repeat (3) @(negedge clk);
        check("async_rst_tick", int'(bus.half_tick), 0);
        reset = 1'b1;
        wait_until(cyc + 50);
        check("post_rst_active", int'(bus.active), 0);
        check("post_rst_tone", int'(bus.tone), 0);

`ifdef TONE_CYCLE_CNT_EN
        // period counter: 3 after 3 rises, saturates at 255, clears on IDLE
        h3 = h_exp(11, 6);
        n = cyc;
        bus.key_on = 1'b1; bus.note_sel = 4'd11; bus.octave = 3'd6;
        t = n + 1;
        for (int k = 1; k <= 6; k++) begin
            t += h3;
            push(t, logic'(k % 2 == 1));
        end
        wait_empty(5000);
        check("cycles_3", int'(bus.cycles), 3);
        for (int k = 7; k <= 600; k++) begin
            t += h3;
            push(t, logic'(k % 2 == 1));
        end
        wait_empty(70000);
        check("cycles_sat", int'(bus.cycles), 255);
        bus.key_on = 1'b0;
        wait_until(cyc + 2);
        check("cycles_clear", int'(bus.cycles), 0);
`endif

        check("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
